// File: rtl/register_file_2reg.sv
// -----------------------------------------------------------------------------
// register_file_2reg
//
// Two-entry operand store for the CPU datapath. The result bus is written into
// one of two WIDTH-bit registers (R0, R1) on the rising clock edge, and two
// independent combinational read ports supply the two ALU operands.
//
// Ports:
//   clk      in   1      clock; writes occur on the rising edge
//   reset    in   1      asynchronous, active-high; clears R0 and R1
//   Input    in   WIDTH  write data (result bus)
//   seti     in   1      write select: 0 = R0, 1 = R1
//   WR       in   1      write enable, active-high
//   seto1    in   1      read select for Output1: 0 = R0, 1 = R1
//   seto2    in   1      read select for Output2: 0 = R0, 1 = R1
//   Output1  out  WIDTH  R[seto1], combinational
//   Output2  out  WIDTH  R[seto2], combinational
//
// There is no write-to-read bypass: a read of the register being written shows
// the old value until the capturing edge and the new value right after it.
// -----------------------------------------------------------------------------
module register_file_2reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] Input,
  input  logic             seti,
  input  logic             WR,
  input  logic             seto1,
  input  logic             seto2,
  output logic [WIDTH-1:0] Output1,
  output logic [WIDTH-1:0] Output2
);

  logic [WIDTH-1:0] r0_q, r0_d;
  logic [WIDTH-1:0] r1_q, r1_d;

  // Next-state: only the selected register takes Input, and only when WR=1.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no
    // path through the block leaves it unassigned (which would infer a latch).
    r0_d = r0_q;
    r1_d = r1_q;
    if (WR) begin
      if (seti) r1_d = Input;
      else      r0_d = Input;
    end
  end

  // Storage. Reset is asynchronous and has priority over any write.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the register file is only two entries of flops, so both are
    // reset explicitly; a larger RAM-style array would normally not be.
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples its pre-edge inputs regardless of statement order.
      r0_q <= '0;
      r1_q <= '0;
    end else begin
      r0_q <= r0_d;
      r1_q <= r1_d;
    end
  end

  // Two independent read muxes straight off the register outputs.
  assign Output1 = seto1 ? r1_q : r0_q;
  assign Output2 = seto2 ? r1_q : r0_q;

endmodule

// File: tb/tb_register_file_2reg.sv
// -----------------------------------------------------------------------------
// tb_register_file_2reg
//
// Directed sequence followed by randomized cycles, all checked against a
// two-element array holding what the register file should contain.
// Stimulus changes on the falling edge; outputs are sampled 1 ns after the
// falling edge (pre-write view) and 1 ns after the rising edge (post-write).
// -----------------------------------------------------------------------------
module tb_register_file_2reg;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] Input;
  logic             seti;
  logic             WR;
  logic             seto1;
  logic             seto2;
  logic [WIDTH-1:0] Output1;
  logic [WIDTH-1:0] Output2;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference contents of R0 and R1.
  logic [WIDTH-1:0] model [2];

  register_file_2reg #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .Input   (Input),
    .seti    (seti),
    .WR      (WR),
    .seto1   (seto1),
    .seto2   (seto2),
    .Output1 (Output1),
    .Output2 (Output2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".out1"}, Output1, model[seto1]);
    check({tag, ".out2"}, Output2, model[seto2]);
  endtask

  // One clock cycle: drive on the falling edge, check the pre-edge view
  // (old contents, or zero if reset is asserted), then check after the edge.
  task automatic cycle(input string tag, input logic rst, input logic wr,
                       input logic si, input logic [WIDTH-1:0] din,
                       input logic s1, input logic s2);
    @(negedge clk);
    reset = rst; WR = wr; seti = si; Input = din; seto1 = s1; seto2 = s2;
    #1;
    if (rst) begin
      model[0] = '0;
      model[1] = '0;
    end
    check_outputs({tag, ".pre"});
    @(posedge clk);
    #1;
    if (!rst && wr) model[si] = din;
    check_outputs({tag, ".post"});
  endtask

  initial begin
    model[0] = '0;
    model[1] = '0;

    // Reset asserted at time 0 with WR=0.
    reset = 1'b1; Input = 567; WR = 1'b0; seti = 1'b0; seto1 = 1'b0; seto2 = 1'b1;
    #1;
    check("reset.out1", Output1, '0);
    check("reset.out2", Output2, '0);

    // Reset held across edges with WR=1: still zero.
    for (int i = 0; i < 3; i++) cycle("reset_wr", 1'b1, 1'b1, i[0], 567, 1'b0, 1'b1);

    // Idle after reset, seti toggling, WR=0.
    for (int i = 0; i < 4; i++) cycle("idle", 1'b0, 1'b0, i[0], 567, 1'b0, 1'b1);

    // Write R0; pre-edge check inside cycle() shows the old value (no bypass).
    cycle("wr_r0", 1'b0, 1'b1, 1'b0, 567, 1'b0, 1'b1);
    check("wr_r0.abs1", Output1, 567);
    check("wr_r0.abs2", Output2, 0);

    // Write R1, then overwrite it.
    cycle("wr_r1", 1'b0, 1'b1, 1'b1, 567, 1'b0, 1'b1);
    check("wr_r1.abs2", Output2, 567);
    cycle("wr_r1b", 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
    check("wr_r1b.abs1", Output1, 567);
    check("wr_r1b.abs2", Output2, 32'hDEAD_BEEF);

    // Read-port independence, no clock edge involved.
    @(negedge clk);
    WR = 1'b0; seto1 = 1'b1; seto2 = 1'b0;
    #1;
    check("swap.out1", Output1, 32'hDEAD_BEEF);
    check("swap.out2", Output2, 567);
    seto2 = 1'b1;
    #1;
    check("same.out1", Output1, 32'hDEAD_BEEF);
    check("same.out2", Output2, 32'hDEAD_BEEF);

    // Async reset pulse between edges clears immediately.
    #1;
    reset = 1'b1;
    #1;
    check("async_rst.out1", Output1, '0);
    check("async_rst.out2", Output2, '0);
    model[0] = '0;
    model[1] = '0;
    // A write attempted during reset is ignored.
    cycle("wr_in_rst", 1'b1, 1'b1, 1'b0, 32'h1234_5678, 1'b0, 1'b1);
    // First write after release lands on the first rising edge.
    cycle("post_rst", 1'b0, 1'b1, 1'b0, 32'h1234_5678, 1'b0, 1'b1);
    check("post_rst.abs1", Output1, 32'h1234_5678);

    // Randomized cycles with occasional reset.
    for (int i = 0; i < 300; i++) begin
      logic rst;
      rst = ($urandom_range(15) == 0);
      cycle("rand", rst, 1'($urandom), 1'($urandom), WIDTH'($urandom),
            1'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
